ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a 2-word x 8-bit RAM.
// Each access runs IDLE -> ACCESS -> RESP. The winner's operands are
// captured in IDLE, so later changes on the port cannot disturb an access
// that is already in flight.
module ram_arbiter (
  input  logic       clk,
  input  logic       clear,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic       addr_a,
  input  logic       addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       ram_addr,
  output logic       ram_r_w,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
  output logic       ram_clear
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       winB_q, winB_d;
  logic       we_q, we_d;
  logic       addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       lastB_q, lastB_d;
  logic [7:0] rdata_q, rdata_d;
  logic       pickB;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign pickB = req_b & (~req_a | ~lastB_q);

  // Next-state logic: arbitrate and capture operands in IDLE, sample read data at the end of ACCESS.
  always_comb begin
    state_d = state_q;
    winB_d  = winB_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lastB_d = lastB_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          winB_d  = pickB;
          lastB_d = pickB;
          we_d    = pickB ? we_b    : we_a;
          addr_d  = pickB ? addr_b  : addr_a;
          wdata_d = pickB ? wdata_b : wdata_a;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = ram_dout;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers. Clear aborts any access in flight and
  // points last-served at B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      winB_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 1'b0;
      wdata_q <= 8'h00;
      lastB_q <= 1'b1;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      winB_q  <= winB_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lastB_q <= lastB_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode. The RAM bus is idle-zero outside ACCESS, and every output
  // is gated by clear so an aborted access can never commit a write.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    done_a   = 1'b0;
    done_b   = 1'b0;
    ram_addr = 1'b0;
    ram_r_w  = 1'b0;
    ram_din  = 8'h00;
    busy     = 1'b0;
    if (!clear) begin
      busy = (state_q != IDLE);
      case (state_q)
        ACCESS: begin
          gnt_a    = ~winB_q;
          gnt_b    = winB_q;
          ram_addr = addr_q;
          ram_r_w  = we_q;
          ram_din  = wdata_q;
        end
        RESP: begin
          done_a = ~winB_q;
          done_b = winB_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign ram_clear = clear;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural 2x8 RAM attached.
// Directed sequences push expected grants and completions into queues;
// a monitor on the falling edge pops and compares as the DUT presents them.
module tb_ram_arbiter;

  logic       clk;
  logic       clear;
  logic       req_a, req_b, we_a, we_b, addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [7:0] rdata;
  logic       busy, ram_addr, ram_r_w, ram_clear;
  logic [7:0] ram_din, ram_dout;

  typedef struct {
    bit         port;
    bit         addr;
    bit         rw;
    logic [7:0] din;
    int         cyc;
  } gntExp_t;

  typedef struct {
    bit         port;
    bit         isRead;
    logic [7:0] rdata;
    int         cyc;
  } doneExp_t;

  gntExp_t    gntQ[$];
  doneExp_t   doneQ[$];
  gntExp_t    gCur;
  doneExp_t   dCur;
  int         nTests = 0;
  int         nFail = 0;
  int         cyc = 0;
  int         doneCount = 0;
  int         base;
  int         doneBefore;
  logic [7:0] mem [2];

  ram_arbiter dut (
    .clk(clk), .clear(clear),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_r_w(ram_r_w),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_clear(ram_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used for latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: synchronous write and clear, combinational read.
  always @(posedge clk) begin
    if (ram_clear) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
    end else if (ram_r_w) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushGnt(input bit p, input bit a, input bit rw, input logic [7:0] d, input int c);
    gntQ.push_back('{port: p, addr: a, rw: rw, din: d, cyc: c});
  endtask

  task automatic pushDone(input bit p, input bit rd, input logic [7:0] d, input int c);
    doneQ.push_back('{port: p, isRead: rd, rdata: d, cyc: c});
  endtask

  // Raise a request, hold it until the port's done pulse, then drop it.
  task automatic applyStimulus(input bit p, input bit we, input bit addr, input logic [7:0] wd);
    int n;
    n = 0;
    if (p == 1'b0) begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end
    do begin
      @(negedge clk);
      n++;
    end while (((p == 1'b0) ? done_a : done_b) !== 1'b1 && n < 40);
    if (n >= 40) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL timeout port %0d: got no done, expected done within 40 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 1'b0) req_a = 1'b0;
    else           req_b = 1'b0;
  endtask

  // Monitor: compare every grant and completion against the scoreboard.
  always @(negedge clk) begin
    if (clear === 1'b0) begin
      if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
        checkOutput("gnt exclusive", {31'd0, gnt_a & gnt_b}, 32'd0);
        if (gntQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL unexpected gnt: got gnt_a=%0b gnt_b=%0b expected none", gnt_a, gnt_b);
        end else begin
          gCur = gntQ.pop_front();
          checkOutput("gnt port", {31'd0, gnt_b}, {31'd0, gCur.port});
          checkOutput("ram_addr", {31'd0, ram_addr}, {31'd0, gCur.addr});
          checkOutput("ram_r_w", {31'd0, ram_r_w}, {31'd0, gCur.rw});
          checkOutput("ram_din", {24'd0, ram_din}, {24'd0, gCur.din});
          checkOutput("busy in access", {31'd0, busy}, 32'd1);
          if (gCur.cyc >= 0) checkOutput("gnt cycle", cyc, gCur.cyc);
        end
      end
      if (done_a === 1'b1 || done_b === 1'b1) begin
        doneCount++;
        checkOutput("done exclusive", {31'd0, done_a & done_b}, 32'd0);
        checkOutput("gnt low in resp", {31'd0, gnt_a | gnt_b}, 32'd0);
        if (doneQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL unexpected done: got done_a=%0b done_b=%0b expected none", done_a, done_b);
        end else begin
          dCur = doneQ.pop_front();
          checkOutput("done port", {31'd0, done_b}, {31'd0, dCur.port});
          if (dCur.isRead) checkOutput("rdata", {24'd0, rdata}, {24'd0, dCur.rdata});
          if (dCur.cyc >= 0) checkOutput("done cycle", cyc, dCur.cyc);
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected end before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = 1'b0; addr_b = 1'b0; wdata_a = 8'h00; wdata_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Outputs while clear is held
    checkOutput("reset gnt_a", {31'd0, gnt_a}, 32'd0);
    checkOutput("reset gnt_b", {31'd0, gnt_b}, 32'd0);
    checkOutput("reset done_a", {31'd0, done_a}, 32'd0);
    checkOutput("reset done_b", {31'd0, done_b}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset ram_r_w", {31'd0, ram_r_w}, 32'd0);
    checkOutput("reset ram_addr", {31'd0, ram_addr}, 32'd0);
    checkOutput("reset ram_din", {24'd0, ram_din}, 32'd0);
    checkOutput("reset ram_clear", {31'd0, ram_clear}, 32'd1);
    checkOutput("reset rdata", {24'd0, rdata}, 32'd0);
    clear = 1'b0;
    #1;
    checkOutput("idle busy", {31'd0, busy}, 32'd0);
    checkOutput("idle ram_clear", {31'd0, ram_clear}, 32'd0);

    // Single write: A writes 0xA5 to word 1
    pushGnt(1'b0, 1'b1, 1'b1, 8'hA5, cyc + 1);
    pushDone(1'b0, 1'b0, 8'h00, cyc + 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);

    // Read back through B, then a write must not disturb rdata
    pushGnt(1'b1, 1'b1, 1'b0, 8'h00, cyc + 1);
    pushDone(1'b1, 1'b1, 8'hA5, cyc + 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    pushGnt(1'b0, 1'b0, 1'b1, 8'h5A, cyc + 1);
    pushDone(1'b0, 1'b0, 8'h00, cyc + 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
    checkOutput("rdata hold", {24'd0, rdata}, 32'h0000_00A5);

    // Tie held through clear release: A first, B three cycles later
    @(posedge clk);
    #1;
    clear = 1'b1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 1'b0; wdata_a = 8'h3C;
    req_b = 1'b1; we_b = 1'b1; addr_b = 1'b0; wdata_b = 8'hC3;
    @(posedge clk);
    #1;
    clear = 1'b0;
    base = cyc;
    pushGnt(1'b0, 1'b0, 1'b1, 8'h3C, base + 1);
    pushDone(1'b0, 1'b0, 8'h00, base + 2);
    pushGnt(1'b1, 1'b0, 1'b1, 8'hC3, base + 4);
    pushDone(1'b1, 1'b0, 8'h00, base + 5);
    fork
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hC3);
    join
    pushGnt(1'b1, 1'b0, 1'b0, 8'h00, cyc + 1);
    pushDone(1'b1, 1'b1, 8'hC3, cyc + 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Continuous contention: A writes 1,2,3 to word 0 and B reads each back
    base = cyc;
    for (int i = 0; i < 3; i++) begin
      pushGnt(1'b0, 1'b0, 1'b1, 8'(i + 1), base + 1 + 6 * i);
      pushDone(1'b0, 1'b0, 8'h00, base + 2 + 6 * i);
      pushGnt(1'b1, 1'b0, 1'b0, 8'h00, base + 4 + 6 * i);
      pushDone(1'b1, 1'b1, 8'(i + 1), base + 5 + 6 * i);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(i + 1));
      end
      begin
        for (int j = 0; j < 3; j++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      end
    join

    // Operand change during ACCESS must not reach the RAM
    pushGnt(1'b0, 1'b1, 1'b1, 8'h12, cyc + 1);
    pushDone(1'b0, 1'b0, 8'h00, cyc + 2);
    fork
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h12);
      begin
        @(posedge clk);
        #2;
        wdata_a = 8'h34;
      end
    join
    pushGnt(1'b1, 1'b1, 1'b0, 8'h00, cyc + 1);
    pushDone(1'b1, 1'b1, 8'h12, cyc + 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);

    // Abort: word 0 holds 0x11, a write of 0xFF is killed by clear in ACCESS
    pushGnt(1'b0, 1'b0, 1'b1, 8'h11, cyc + 1);
    pushDone(1'b0, 1'b0, 8'h00, cyc + 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11);
    doneBefore = doneCount;
    req_a = 1'b1; we_a = 1'b1; addr_a = 1'b0; wdata_a = 8'hFF;
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    req_a = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort no done", doneCount, doneBefore);
    @(posedge clk);
    #1;
    pushGnt(1'b0, 1'b0, 1'b0, 8'h00, cyc + 1);
    pushDone(1'b0, 1'b1, 8'h00, cyc + 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    checkOutput("gnt queue drained", gntQ.size(), 32'd0);
    checkOutput("done queue drained", doneQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
